// File: rtl/dla_ddr_feeder.sv
// DLA DDR stimulus feeder: registers the lane grid and walks the per-row
// write-enable burst schedule (BURST_LEN writes, GAP_CYCLES idle, next row).
module dla_ddr_feeder #(
    parameter int NUM_ROWS   = 6,
    parameter int NUM_COLS   = 4,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 8,
    parameter int GAP_CYCLES = 4,
    localparam int LANES     = NUM_ROWS * NUM_COLS,
    localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [LANES*DATA_W-1:0] i_data,
    output logic [LANES-1:0]        o_ddr_wen,
    output logic [LANES*DATA_W-1:0] o_ddr_data,
    output logic [ROW_W-1:0]        o_row,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BEAT_W = ($clog2(BURST_LEN + 1) > 0) ? $clog2(BURST_LEN + 1) : 1;
    localparam int GAP_W  = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
    localparam bit                HAS_GAP   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_n;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_n;
    logic [ROW_W-1:0]    row_n;
    logic [LANES-1:0]    wen_n;
    logic                busy_n;
    logic                done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            o_row      <= '0;
            o_ddr_wen  <= '0;
            o_ddr_data <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_n;
            gap_cnt    <= gap_n;
            o_row      <= row_n;
            o_ddr_wen  <= wen_n;
            o_ddr_data <= i_data;
            o_busy     <= busy_n;
            o_done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        beat_n  = beat_cnt;
        gap_n   = gap_cnt;
        row_n   = o_row;
        if (i_abort) begin
            state_n = IDLE;
            beat_n  = '0;
            gap_n   = '0;
            row_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state_n = BURST;
                        row_n   = '0;
                        beat_n  = '0;
                    end
                end
                BURST: begin
                    if (beat_cnt == BEAT_LAST) begin
                        if (o_row == ROW_LAST) begin
                            state_n = DONE;
                        end else if (HAS_GAP) begin
                            state_n = GAP;
                            gap_n   = '0;
                        end else begin
                            // back-to-back rows: no bubble between bursts
                            state_n = BURST;
                            row_n   = o_row + ROW_W'(1);
                            beat_n  = '0;
                        end
                    end else begin
                        beat_n = beat_cnt + BEAT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = BURST;
                        row_n   = o_row + ROW_W'(1);
                        beat_n  = '0;
                    end else begin
                        gap_n = gap_cnt + GAP_W'(1);
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        wen_n  = '0;
        busy_n = (state_n == BURST) || (state_n == GAP);
        done_n = (state_n == DONE);
        for (int r = 0; r < NUM_ROWS; r++) begin
            if ((state_n == BURST) && (row_n == ROW_W'(r))) begin
                wen_n[r*NUM_COLS +: NUM_COLS] = '1;
            end
        end
    end

endmodule

// File: tb/tb_dla_ddr_feeder.sv
// Bench for dla_ddr_feeder: default schedule and a back-to-back variant
// (BURST_LEN=1, GAP_CYCLES=0) checked every cycle against a schedule model.
module tb_dla_ddr_feeder;

    localparam int ROWS  = 6;
    localparam int COLS  = 4;
    localparam int DW    = 16;
    localparam int LANES = ROWS * COLS;
    localparam int DBITS = LANES * DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [DBITS-1:0] data;

    logic [LANES-1:0] wen  [2];
    logic [DBITS-1:0] dd   [2];
    logic [2:0]       row  [2];
    logic             busy [2];
    logic             done [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    bit               m_act  [2];
    int               m_e    [2];
    int               m_hold [2];
    logic [DBITS-1:0] m_data;

    always #5 clk = ~clk;

    dla_ddr_feeder dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_data     (data),
        .o_ddr_wen  (wen[0]),
        .o_ddr_data (dd[0]),
        .o_row      (row[0]),
        .o_busy     (busy[0]),
        .o_done     (done[0])
    );

    dla_ddr_feeder #(
        .BURST_LEN  (1),
        .GAP_CYCLES (0)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_data     (data),
        .o_ddr_wen  (wen[1]),
        .o_ddr_data (dd[1]),
        .o_row      (row[1]),
        .o_busy     (busy[1]),
        .o_done     (done[1])
    );

    function automatic int bl_of(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    task automatic chk(input string name, input logic [DBITS-1:0] act,
                       input logic [DBITS-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Pass position e counts cycles since the start edge: e=1 is the first
    // burst cycle, e=total+1 is the done cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int total;
            total = ROWS * bl_of(i) + (ROWS - 1) * gap_of(i);
            if (rst || abort) begin
                m_act[i]  = 0;
                m_hold[i] = 0;
            end else if (m_act[i]) begin
                if (m_e[i] == total + 1) begin
                    m_act[i]  = 0;
                    m_hold[i] = ROWS - 1;
                end else begin
                    m_e[i] = m_e[i] + 1;
                end
            end else if (start) begin
                m_act[i] = 1;
                m_e[i]   = 1;
            end
        end
        m_data = rst ? '0 : data;
    end

    task automatic model_out(input int i, output logic [LANES-1:0] w,
                             output int r, output bit b, output bit d);
        int bl, gp, per, total, p;
        bl    = bl_of(i);
        gp    = gap_of(i);
        per   = bl + gp;
        total = ROWS * bl + (ROWS - 1) * gp;
        w = '0;
        b = 0;
        d = 0;
        r = m_hold[i];
        if (m_act[i]) begin
            p = m_e[i] - 1;
            if (p < total) begin
                r = p / per;
                b = 1;
                if ((p % per) < bl) w = LANES'(24'hF) << (COLS * r);
            end else begin
                d = 1;
                r = ROWS - 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [LANES-1:0] ew;
                int er;
                bit eb, ed, one_row;
                model_out(i, ew, er, eb, ed);
                chk($sformatf("wen%0d", i), DBITS'(wen[i]), DBITS'(ew));
                chk($sformatf("data%0d", i), dd[i], m_data);
                chk($sformatf("row%0d", i), DBITS'(row[i]), DBITS'(er));
                chk($sformatf("busy%0d", i), DBITS'(busy[i]), DBITS'(eb));
                chk($sformatf("done%0d", i), DBITS'(done[i]), DBITS'(ed));
                one_row = (wen[i] == '0);
                for (int r = 0; r < ROWS; r++) begin
                    if ((wen[i] & ~(LANES'(24'hF) << (COLS * r))) == '0) one_row = 1;
                end
                chk($sformatf("onerow%0d", i), DBITS'(one_row), DBITS'(1'b1));
            end
        end
    end

    task automatic lane_index_data();
        for (int l = 0; l < LANES; l++) data[l*DW +: DW] = DW'(l);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        data  = '0;
        repeat (3) begin
            @(negedge clk);
            chk_en = 1;
            chk("rst_wen", DBITS'(wen[0]), '0);
            chk("rst_busy", DBITS'({busy[0], done[0], row[0]}), '0);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_out", DBITS'({wen[0], busy[0], done[0], row[0]}), '0);
        end

        // full pass with an ignored start inside row 1's gap
        lane_index_data();
        start = 1'b1;
        for (int j = 1; j <= 72; j++) begin
            @(negedge clk);
            if (j == 1 || j == 23) start = 1'b0;
            if (j == 22) start = 1'b1;
            case (j)
                1:  chk("a_j1", DBITS'({wen[0], busy[0], row[0]}), DBITS'({24'h00000F, 1'b1, 3'd0}));
                8:  chk("a_j8", DBITS'(wen[0]), DBITS'(24'h00000F));
                9:  chk("a_j9", DBITS'({wen[0], busy[0], row[0]}), DBITS'({24'h0, 1'b1, 3'd0}));
                13: chk("a_j13", DBITS'({wen[0], row[0]}), DBITS'({24'h0000F0, 3'd1}));
                68: chk("a_j68", DBITS'(wen[0]), DBITS'(24'hF00000));
                69: chk("a_j69", DBITS'({wen[0], done[0], row[0]}), DBITS'({24'h0, 1'b1, 3'd5}));
                70: chk("a_j70", DBITS'({done[0], busy[0], row[0]}), DBITS'({1'b0, 1'b0, 3'd5}));
                default: ;
            endcase
            case (j)
                1: chk("b_j1", DBITS'(wen[1]), DBITS'(24'h00000F));
                6: chk("b_j6", DBITS'(wen[1]), DBITS'(24'hF00000));
                7: chk("b_j7", DBITS'({wen[1], done[1]}), DBITS'({24'h0, 1'b1}));
                default: ;
            endcase
        end

        // abort in row 2 beat 3, then restart
        start = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1 || j == 36) start = 1'b0;
            if (j == 35) start = 1'b1;
            if (j == 27) begin
                chk("ab_pre", DBITS'({wen[0], row[0]}), DBITS'({24'h000F00, 3'd2}));
                abort = 1'b1;
            end
            if (j == 28) begin
                abort = 1'b0;
                chk("ab_post", DBITS'({wen[0], busy[0], done[0], row[0]}), '0);
            end
            if (j == 36) chk("restart", DBITS'({wen[0], row[0]}), DBITS'({24'h00000F, 3'd0}));
        end
        repeat (80) @(negedge clk);

        // counter-driven data across a pass
        start = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int l = 0; l < LANES; l++) data[l*DW +: DW] = DW'(c * 3 + l * 257);
        end

        // random stimulus
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 149) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < DBITS / 32; k++) data[k*32 +: 32] = $urandom;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
